// File: rtl/pc_sequencer.sv
// Program counter owner for the RV32IM core: sequences the FETCH/EXEC handshake,
// selects the next PC, redirects to the trap vector and counts retired instructions.
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          PC_STEP      = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_0100)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_ready_i,
  input  logic                stall_i,
  input  logic                trap_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  input  logic                branch_taken_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc_plus4_o,
  output logic                imem_req_o,
  output logic                instr_valid_o,
  output logic                trap_o,
  output logic [1:0]          cause_o,
  output logic [PC_WIDTH-1:0] epc_o,
  output logic [31:0]         instret_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_TRAP  = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_MIS  = 2'b10;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic [1:0]          cause_q, cause_d;
  logic [31:0]         instret_q, instret_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target;
  logic                redirect;

  assign pc_inc = pc_q + PC_WIDTH'(PC_STEP);

  // Jump outranks branch; only a redirect target is alignment-checked
  always_comb begin
    target   = pc_inc;
    redirect = 1'b0;
    if (jump_i) begin
      target   = jump_target_i;
      redirect = 1'b1;
    end else if (branch_taken_i) begin
      target   = branch_target_i;
      redirect = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ready_i) state_d = ST_EXEC;
      ST_EXEC: begin
        if (!stall_i) begin
          if (trap_i) begin
            epc_d   = pc_q;
            cause_d = CAUSE_EXT;
            state_d = ST_TRAP;
          end else if (redirect && (target[1:0] != 2'b00)) begin
            epc_d   = pc_q;
            cause_d = CAUSE_MIS;
            state_d = ST_TRAP;
          end else begin
            pc_d      = target;
            instret_d = instret_q + 32'd1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake strobes are pure decodes of the registered state
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_inc;
  assign imem_req_o    = (state_q == ST_FETCH);
  assign instr_valid_o = (state_q == ST_EXEC);
  assign trap_o        = (state_q == ST_TRAP);
  assign cause_o       = cause_q;
  assign epc_o         = epc_q;
  assign instret_o     = instret_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle expectations queued at drive time,
// popped and compared one cycle later.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready_i, stall_i, trap_i, jump_i, branch_taken_i;
  logic [31:0] jump_target_i, branch_target_i;
  logic [31:0] pc_o, pc_plus4_o, epc_o, instret_o;
  logic        imem_req_o, instr_valid_o, trap_o;
  logic [1:0]  cause_o, state_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_ready_i(imem_ready_i), .stall_i(stall_i), .trap_i(trap_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .imem_req_o(imem_req_o),
    .instr_valid_o(instr_valid_o), .trap_o(trap_o), .cause_o(cause_o),
    .epc_o(epc_o), .instret_o(instret_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected post-edge view, clock once, then pop and compare
  task automatic cyc(input string tag, input logic [1:0] st, input logic [31:0] pc,
                     input logic [31:0] ir);
    exp_t e;
    sb.push_back('{tag, st, pc, ir});
    step();
    e = sb.pop_front();
    chk({e.tag, ".state"}, 32'(state_o), 32'(e.st));
    chk({e.tag, ".pc"}, pc_o, e.pc);
    chk({e.tag, ".pc4"}, pc_plus4_o, e.pc + 32'd4);
    chk({e.tag, ".ir"}, instret_o, e.ir);
    chk({e.tag, ".req"}, 32'(imem_req_o), 32'(e.st == 2'b01));
    chk({e.tag, ".valid"}, 32'(instr_valid_o), 32'(e.st == 2'b10));
    chk({e.tag, ".trap"}, 32'(trap_o), 32'(e.st == 2'b11));
  endtask

  task automatic clr();
    stall_i = 0; trap_i = 0; jump_i = 0; branch_taken_i = 0;
    jump_target_i = 0; branch_target_i = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, 32'(state_o), 32'd0);
    chk({tag, ".pc"}, pc_o, 32'h0);
    chk({tag, ".req"}, 32'(imem_req_o), 32'd0);
    chk({tag, ".valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, ".trap"}, 32'(trap_o), 32'd0);
    chk({tag, ".cause"}, 32'(cause_o), 32'd0);
    chk({tag, ".epc"}, epc_o, 32'h0);
    chk({tag, ".ir"}, instret_o, 32'd0);
  endtask

  initial begin
    rst_n = 0; imem_ready_i = 0;
    clr();
    repeat (2) step();
    chk_reset("rst");
    rst_n = 1;
    chk("idle.state", 32'(state_o), 32'd0);
    imem_ready_i = 1;

    // Straight-line run: 0,4,8,C
    cyc("f0", 2'd1, 32'h0, 0);  cyc("e0", 2'd2, 32'h0, 0);
    cyc("f4", 2'd1, 32'h4, 1);  cyc("e4", 2'd2, 32'h4, 1);
    cyc("f8", 2'd1, 32'h8, 2);  cyc("e8", 2'd2, 32'h8, 2);
    cyc("fc", 2'd1, 32'hC, 3);  cyc("ec", 2'd2, 32'hC, 3);
    cyc("f10", 2'd1, 32'h10, 4);
    cyc("e10", 2'd2, 32'h10, 4);

    // Stall with pending branch: PC held, then branch taken once
    stall_i = 1; branch_taken_i = 1; branch_target_i = 32'h40;
    for (int i = 0; i < 5; i++) cyc("stall", 2'd2, 32'h10, 4);
    stall_i = 0;
    cyc("br40", 2'd1, 32'h40, 5);
    clr();
    cyc("e40", 2'd2, 32'h40, 5);

    // Jump beats branch
    jump_i = 1; jump_target_i = 32'h200; branch_taken_i = 1; branch_target_i = 32'h80;
    cyc("jprio", 2'd1, 32'h200, 6);
    clr();
    cyc("e200", 2'd2, 32'h200, 6);
    jump_i = 1; jump_target_i = 32'h20;
    cyc("f20", 2'd1, 32'h20, 7);
    clr();
    cyc("e20", 2'd2, 32'h20, 7);

    // Misaligned branch target
    branch_taken_i = 1; branch_target_i = 32'h22;
    cyc("mis", 2'd3, 32'h20, 7);
    clr();
    chk("mis.cause", 32'(cause_o), 32'd2);
    chk("mis.epc", epc_o, 32'h20);
    cyc("tv1", 2'd1, 32'h100, 7);
    cyc("e100a", 2'd2, 32'h100, 7);
    jump_i = 1; jump_target_i = 32'h30;
    cyc("f30", 2'd1, 32'h30, 8);
    clr();
    cyc("e30", 2'd2, 32'h30, 8);

    // External trap
    trap_i = 1; jump_i = 1; jump_target_i = 32'h400;
    cyc("xtrap", 2'd3, 32'h30, 8);
    clr();
    chk("xtrap.cause", 32'(cause_o), 32'd1);
    chk("xtrap.epc", epc_o, 32'h30);
    cyc("tv2", 2'd1, 32'h100, 8);
    cyc("e100b", 2'd2, 32'h100, 8);

    // Sequential wrap at the top of the address space
    jump_i = 1; jump_target_i = 32'hFFFF_FFFC;
    cyc("ftop", 2'd1, 32'hFFFF_FFFC, 9);
    clr();
    cyc("etop", 2'd2, 32'hFFFF_FFFC, 9);
    cyc("wrap", 2'd1, 32'h0, 10);
    chk("wrap.cause", 32'(cause_o), 32'd1);

    // Instruction memory wait states
    imem_ready_i = 0;
    for (int i = 0; i < 3; i++) cyc("wait", 2'd1, 32'h0, 10);
    imem_ready_i = 1;
    cyc("e0b", 2'd2, 32'h0, 10);

    // Misaligned jump with aligned branch: jump target is the one checked
    jump_i = 1; jump_target_i = 32'h202; branch_taken_i = 1; branch_target_i = 32'h80;
    cyc("jmis", 2'd3, 32'h0, 10);
    clr();
    chk("jmis.cause", 32'(cause_o), 32'd2);
    chk("jmis.epc", epc_o, 32'h0);
    cyc("tv3", 2'd1, 32'h100, 10);
    cyc("e100c", 2'd2, 32'h100, 10);

    // Asynchronous reset in the middle of a stall
    stall_i = 1;
    cyc("stall2", 2'd2, 32'h100, 10);
    #2 rst_n = 0;
    #1 chk_reset("arst");
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the program counter for the RV32IM core and sequences instruction fetch and execution. It drives a two-phase FETCH/EXEC handshake with instruction memory. It selects the next PC from sequential, branch, jump or trap sources, and holds the PC during datapath stalls such as a multi-cycle divide. It redirects to the trap vector on external traps and on misaligned targets, and keeps a retired-instruction counter.

## Interface
- PC_WIDTH, 32, width of all address ports
- PC_STEP, 4, sequential increment
- RESET_VECTOR, 32'h0000_0000, PC after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on any trap
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_ready_i  in  1  instruction memory has returned the word at pc_o
- stall_i  in  1  datapath busy; current EXEC instruction not yet complete
- trap_i  in  1  datapath requests a trap for the current instruction
- jump_i  in  1  current instruction is JAL/JALR
- jump_target_i  in  PC_WIDTH  jump destination
- branch_taken_i  in  1  current conditional branch resolved taken
- branch_target_i  in  PC_WIDTH  branch destination
- pc_o  out  PC_WIDTH  registered current PC
- pc_plus4_o  out  PC_WIDTH  pc_o + PC_STEP, combinational, modulo 2^PC_WIDTH
- imem_req_o  out  1  fetch request for pc_o
- instr_valid_o  out  1  fetched instruction valid; datapath may execute
- trap_o  out  1  one-cycle pulse in TRAP state
- cause_o  out  2  last trap cause: 00 none, 01 external (trap_i), 10 misaligned target
- epc_o  out  PC_WIDTH  PC of the trapping instruction
- instret_o  out  32  retired-instruction count
- state_o  out  2  IDLE=00, FETCH=01, EXEC=10, TRAP=11

## Operation
- Reset values: pc_o=RESET_VECTOR, imem_req_o=0, instr_valid_o=0, trap_o=0, cause_o=00, epc_o=0, instret_o=0, state_o=IDLE.
- Asserting rst_n mid-operation aborts any fetch or stall immediately. No partial update survives.
- IDLE: single cycle after reset release, then FETCH unconditionally.
- FETCH: imem_req_o=1, with pc_o held stable while it is asserted. When imem_ready_i=1, go to EXEC next cycle. Otherwise remain in FETCH. imem_ready_i is ignored in all other states.
- EXEC: instr_valid_o=1.
  - If stall_i=1, remain in EXEC with PC held. trap_i, jump_i and branch_taken_i are ignored while stalled.
  - If stall_i=0, resolve in priority order: trap_i > jump_i > branch_taken_i > sequential (pc_plus4_o).
- Trap from trap_i: epc_o<=pc_o, cause_o<=01, go to TRAP.
- Misaligned target: a selected jump or branch target with bits[1:0]≠00 sets epc_o<=pc_o, cause_o<=10, and goes to TRAP. The PC is not loaded with the bad target.
- Non-trapping completion: pc_o<=selected target, instret_o<=instret_o+1, go to FETCH.
- Trapped instructions do not increment instret_o.
- TRAP: trap_o=1 for exactly this cycle. pc_o<=TRAP_VECTOR, then FETCH. cause_o and epc_o hold until the next trap.
- Sequential wrap: pc_o=FFFF_FFFC advances to 0000_0000 with no trap.
- instret_o wraps FFFF_FFFF→0.
- jump_i and branch_taken_i both high: the jump wins, and only the jump target is alignment-checked.

## Timing
- pc_o, state, cause_o, epc_o and instret_o are registered. imem_req_o, instr_valid_o and trap_o are decoded from state.
- After rst_n rises: cycle 0 is IDLE, cycle 1 is FETCH with imem_req_o=1.
- Minimum 2 cycles per instruction: FETCH with imem_ready_i=1, then EXEC with stall_i=0.
- Each FETCH wait cycle and each stall cycle adds exactly 1 cycle.
- Trap path costs 3 cycles: EXEC → TRAP → FETCH at TRAP_VECTOR.
- The new pc_o is visible the cycle after the EXEC or TRAP edge that loads it.

## Test plan
- Reset, then imem_ready_i tied 1 and no controls asserted → pc_o follows 0,4,8,C in alternate FETCH/EXEC cycles; instret_o=4 after 8 cycles following IDLE.
- In EXEC at pc=0x10, hold stall_i=1 for 5 cycles with branch_taken_i=1 (target 0x40), then drop stall_i → pc_o stays 0x10 for all 5 cycles, then becomes 0x40; instret_o increments once.
- In EXEC, assert jump_i (target 0x200) and branch_taken_i (target 0x80) together → pc_o=0x200.
- In EXEC at pc=0x20, set branch_taken_i=1 with target 0x22 → TRAP with trap_o pulse, epc_o=0x20, cause_o=10, next pc_o=0x100, instret_o unchanged.
- trap_i=1 at pc=0x30 → cause_o=01, epc_o=0x30, pc_o=0x100.
- PC at FFFF_FFFC with sequential advance → pc_o=0000_0000 and no trap.
- Hold imem_ready_i=0 for 3 cycles → imem_req_o stays high with pc stable.
- Pulse rst_n low mid-stall → all outputs return to their reset values asynchronously.
